// File: rtl/xs3_dec_seq.sv
// Sequential Excess-3 decoder: collects NDIGITS XS-3 digits (MSD first) into BCD and binary.
// Optional macro XS3_ERR_ABORT_EN: an invalid code aborts the frame immediately with out_err set.
module xs3_dec_seq #(
  parameter int unsigned NDIGITS = 3,
  parameter int unsigned OUT_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_digit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_bcd,
  output logic [OUT_W-1:0]       out_bin,
  output logic                   out_err
);

  localparam int unsigned CNT_W = $clog2(NDIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*NDIGITS-1:0]  bcd_q, bcd_d;
  logic [OUT_W-1:0]      bin_q, bin_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  code_ok;
  logic [3:0]            dig;
  logic [4*NDIGITS+3:0]  bcd_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    accept    = in_valid && (state_q == ST_ACC);
    code_ok   = (in_digit >= 4'd3) && (in_digit <= 4'd12);
    dig       = code_ok ? (in_digit - 4'd3) : 4'd0;
    // Shift via a wider temporary so NDIGITS=1 needs no empty slice.
    bcd_shift = {bcd_q, dig};

    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    err_d   = err_q;

    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          bcd_d = bcd_shift[4*NDIGITS-1:0];
          bin_d = (bin_q << 3) + (bin_q << 1) + OUT_W'(dig);
          err_d = err_q | ~code_ok;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_OUT;
          end
`ifdef XS3_ERR_ABORT_EN
          if (!code_ok) begin
            bcd_d   = '0;
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = ST_OUT;
          end
`endif
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACC;
          cnt_d   = '0;
          bcd_d   = '0;
          bin_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_OUT);
    out_bcd   = out_valid ? bcd_q : '0;
    out_bin   = out_valid ? bin_q : '0;
    out_err   = out_valid ? err_q : 1'b0;
  end

endmodule

// File: tb/tb_xs3_dec_seq.sv
// Directed self-checking bench for xs3_dec_seq (NDIGITS=3, OUT_W=10).
module tb_xs3_dec_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_digit;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic [9:0]  out_bin;
  logic        out_err;

  int tests;
  int fails;

  xs3_dec_seq #(.NDIGITS(3), .OUT_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_bin   (out_bin),
    .out_err   (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a negedge; presents one digit for one accepting edge, returns at the next negedge.
  task automatic drive_digit(input logic [3:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL drive_timeout: in_ready=%0b required=1 after %0d cycles", in_ready, n);
    end
    in_valid = 1'b1;
    in_digit = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    tests++; if (out_bcd !== 12'h000) begin fails++; $display("FAIL reset_out_bcd: got %h want 000", out_bcd); end
    tests++; if (out_bin !== 10'd0)   begin fails++; $display("FAIL reset_out_bin: got %0d want 0", out_bin); end
    tests++; if (out_err !== 1'b0)    begin fails++; $display("FAIL reset_out_err: got %0b want 0", out_err); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_digit(4'h4);
    drive_digit(4'h5);
    drive_digit(4'h6);
    tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    tests++; if (out_bcd !== 12'h123) begin fails++; $display("FAIL basic_bcd: got %h want 123", out_bcd); end
    tests++; if (out_bin !== 10'd123) begin fails++; $display("FAIL basic_bin: got %0d want 123", out_bin); end
    tests++; if (out_err !== 1'b0)    begin fails++; $display("FAIL basic_err: got %0b want 0", out_err); end
    tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL basic_in_ready: got %0b want 0", in_ready); end
    step();
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL basic_exit_valid: got %0b want 0", out_valid); end
    tests++; if (out_bin !== 10'd0)   begin fails++; $display("FAIL basic_exit_bin: got %0d want 0", out_bin); end
    tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL basic_exit_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_extremes();
    out_ready = 1'b1;
    drive_digit(4'hC);
    drive_digit(4'hC);
    drive_digit(4'hC);
    tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL max_valid: got %0b want 1", out_valid); end
    tests++; if (out_bcd !== 12'h999) begin fails++; $display("FAIL max_bcd: got %h want 999", out_bcd); end
    tests++; if (out_bin !== 10'd999) begin fails++; $display("FAIL max_bin: got %0d want 999", out_bin); end
    step();
    drive_digit(4'h3);
    drive_digit(4'h3);
    drive_digit(4'h3);
    tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL zero_valid: got %0b want 1", out_valid); end
    tests++; if (out_bcd !== 12'h000) begin fails++; $display("FAIL zero_bcd: got %h want 000", out_bcd); end
    tests++; if (out_bin !== 10'd0)   begin fails++; $display("FAIL zero_bin: got %0d want 0", out_bin); end
    tests++; if (out_err !== 1'b0)    begin fails++; $display("FAIL zero_err: got %0b want 0", out_err); end
    step();
  endtask

  task automatic test_invalid();
    out_ready = 1'b1;
`ifdef XS3_ERR_ABORT_EN
    drive_digit(4'h4);
    drive_digit(4'hF);
    tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL abort_valid: got %0b want 1", out_valid); end
    tests++; if (out_bin !== 10'd0)   begin fails++; $display("FAIL abort_bin: got %0d want 0", out_bin); end
    tests++; if (out_bcd !== 12'h000) begin fails++; $display("FAIL abort_bcd: got %h want 000", out_bcd); end
    tests++; if (out_err !== 1'b1)    begin fails++; $display("FAIL abort_err: got %0b want 1", out_err); end
    step();
    drive_digit(4'h6);
    drive_digit(4'h4);
    drive_digit(4'h5);
    tests++; if (out_bcd !== 12'h312) begin fails++; $display("FAIL abort_resync_bcd: got %h want 312", out_bcd); end
    tests++; if (out_bin !== 10'd312) begin fails++; $display("FAIL abort_resync_bin: got %0d want 312", out_bin); end
    tests++; if (out_err !== 1'b0)    begin fails++; $display("FAIL abort_resync_err: got %0b want 0", out_err); end
`else
    drive_digit(4'h4);
    drive_digit(4'hF);
    drive_digit(4'h6);
    tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL inv_valid: got %0b want 1", out_valid); end
    tests++; if (out_bcd !== 12'h103) begin fails++; $display("FAIL inv_bcd: got %h want 103", out_bcd); end
    tests++; if (out_bin !== 10'd103) begin fails++; $display("FAIL inv_bin: got %0d want 103", out_bin); end
    tests++; if (out_err !== 1'b1)    begin fails++; $display("FAIL inv_err: got %0b want 1", out_err); end
    step();
    drive_digit(4'h5);
    drive_digit(4'h5);
    drive_digit(4'h5);
    tests++; if (out_err !== 1'b0)    begin fails++; $display("FAIL inv_err_cleared: got %0b want 0", out_err); end
`endif
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_digit(4'h7);
    drive_digit(4'h8);
    drive_digit(4'h9);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_digit = 4'h3;
      tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL hold_valid[%0d]: got %0b want 1", i, out_valid); end
      tests++; if (out_bin !== 10'd456) begin fails++; $display("FAIL hold_bin[%0d]: got %0d want 456", i, out_bin); end
      tests++; if (out_bcd !== 12'h456) begin fails++; $display("FAIL hold_bcd[%0d]: got %h want 456", i, out_bcd); end
      tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL hold_in_ready[%0d]: got %0b want 0", i, in_ready); end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++; if (out_bin !== 10'd456) begin fails++; $display("FAIL hold_release_bin: got %0d want 456", out_bin); end
    step();
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL release_valid: got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    tests++; if (out_bin !== 10'd0)   begin fails++; $display("FAIL release_bin: got %0d want 0", out_bin); end
    tests++; if (out_bcd !== 12'h000) begin fails++; $display("FAIL release_bcd: got %h want 000", out_bcd); end
  endtask

  task automatic test_reset_mid_frame();
    int gap;
    out_ready = 1'b1;
    drive_digit(4'h4);
    drive_digit(4'h4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
    for (int k = 0; k < 3; k++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        in_digit = 4'h9;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL gap_valid[%0d]: got %0b want 0", k, out_valid); end
      end
      drive_digit(4'h5);
      if (k < 2) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL partial_valid[%0d]: got %0b want 0", k, out_valid); end
      end
    end
    tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL midrst_frame_valid: got %0b want 1", out_valid); end
    tests++; if (out_bin !== 10'd222) begin fails++; $display("FAIL midrst_bin: got %0d want 222", out_bin); end
    tests++; if (out_bcd !== 12'h222) begin fails++; $display("FAIL midrst_bcd: got %h want 222", out_bcd); end
    step();
  endtask

  task automatic test_reset_in_hold();
    out_ready = 1'b0;
    drive_digit(4'h6);
    drive_digit(4'h6);
    drive_digit(4'h6);
    tests++; if (out_bin !== 10'd333) begin fails++; $display("FAIL hold_rst_pre_bin: got %0d want 333", out_bin); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL hold_rst_valid: got %0b want 0", out_valid); end
    tests++; if (out_bin !== 10'd0)   begin fails++; $display("FAIL hold_rst_bin: got %0d want 0", out_bin); end
    tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL hold_rst_in_ready: got %0b want 1", in_ready); end
    out_ready = 1'b1;
    drive_digit(4'h3);
    drive_digit(4'h4);
    drive_digit(4'hB);
    tests++; if (out_bin !== 10'd18)  begin fails++; $display("FAIL post_rst_bin: got %0d want 18", out_bin); end
    tests++; if (out_bcd !== 12'h018) begin fails++; $display("FAIL post_rst_bcd: got %h want 018", out_bcd); end
    step();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_digit  = 4'h0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_extremes();
    test_invalid();
    test_backpressure();
    test_reset_mid_frame();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xs3_dec_seq.md
Name: xs3_dec_seq

Overview:
- Sequential Excess-3 decoder. Inverse of the team's Add3 encoder family.
- Accepts a stream of 4-bit Excess-3 digits, most significant digit first, over a valid/ready handshake.
- Subtracts 3 from each digit, validates the code, and accumulates a frame of NDIGITS digits.
- Emits each frame as a packed BCD word plus its binary value, also over valid/ready.
- Sits between the XS-3 encoded datapath and binary consumers.

Parameters:
- NDIGITS, 3, number of XS-3 digits per frame (≥1).
- OUT_W, 10, width of binary result. Must hold 10^NDIGITS-1; wider values are zero-extended, narrower values truncate mod 2^OUT_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  in_digit holds a digit.
- in_ready  output  1  block can accept a digit this cycle.
- in_digit  input  4  Excess-3 coded decimal digit.
- out_valid  output  1  frame result held on out_* buses.
- out_ready  input  1  consumer accepts result this cycle.
- out_bcd  output  4*NDIGITS  decoded BCD, first-received digit in the MS nibble.
- out_bin  output  OUT_W  binary value of the frame.
- out_err  output  1  frame contained at least one invalid XS-3 code.

Behaviour:
- States: ACC (collecting digits), OUT (holding result). Reset state is ACC.
- Reset values:
  - in_ready=1 (combinational from ACC), out_valid=0, out_bcd=0, out_bin=0, out_err=0.
  - Digit count=0, accumulators cleared.
- in_ready=1 exactly when state is ACC; out_valid=1 exactly when state is OUT.
- Digit accept: a digit is taken when in_valid & in_ready on a rising edge.
- Code validity:
  - Valid codes are 4'b0011..4'b1100, decoding to d = in_digit-3 (0..9).
  - Codes 0000, 0001, 0010, 1101, 1110 and 1111 are invalid; they decode as d=0 and set the sticky frame error.
- Update per accepted digit:
  - bcd <= {bcd[4*NDIGITS-5:0], d}
  - bin <= bin*10 + d, computed in OUT_W bits, wrap mod 2^OUT_W.
  - count <= count+1.
- Frame completion:
  - When the NDIGITS-th digit is accepted, the next cycle enters OUT.
  - out_* reflect the complete frame in that cycle, so latency is 1 cycle from the last digit accept to out_valid.
- In OUT:
  - in_ready=0; in_valid and in_digit are ignored.
  - out_bcd, out_bin and out_err are held stable while out_valid & !out_ready.
- Output handshake:
  - On out_valid & out_ready, return to ACC next cycle with count, bcd, bin and err cleared.
  - Minimum frame period is NDIGITS+1 cycles.
- in_valid low in ACC: state is held and gaps of any length are allowed.
- When no frame is held (ACC), out_bcd, out_bin and out_err show 0. They change only on entry to OUT, and are cleared on exit.
- rst_n low in any state (mid-frame, or mid-hold with out_valid=1): all state returns to reset values on that edge. Any partial frame or held result is discarded and no output is produced for it.
- NDIGITS=1: every accepted digit produces a frame.

Optional Feature:
- Macro: XS3_ERR_ABORT_EN.
- Defined:
  - An invalid code aborts the frame. The next cycle enters OUT with out_err=1, out_bin=0 and out_bcd=0, regardless of digits already accepted.
  - The count resets on the output handshake. The remaining digits of the aborted frame are treated as the start of a new frame; the upstream block must resynchronise.
- Undefined: the frame runs to NDIGITS digits; invalid digits decode as 0 and set the sticky out_err, as described in Behaviour.

Test Plan:
- Reset, then digits 4'h4, 4'h5, 4'h6 back-to-back with out_ready=1 → one cycle after the 3rd accept: out_valid=1, out_bcd=12'h123, out_bin=123, out_err=0; in_ready=0 for that cycle.
- Digits 4'hC ×3 → out_bcd=12'h999, out_bin=999; digits 4'h3 ×3 → out_bcd=0, out_bin=0, out_err=0.
- Macro undefined, digits 4'h4, 4'hF, 4'h6 → out_bcd=12'h103, out_bin=103, out_err=1. Macro defined, same stimulus → OUT entered the cycle after 4'hF is accepted with out_bin=0, out_err=1; 4'h6 then starts a new frame.
- Frame 4'h7, 4'h8, 4'h9 with out_ready=0 for 5 cycles → out_valid held with out_bin=456 stable and in_ready=0 throughout. out_ready=1 → back to ACC the next cycle, outputs 0.
- Two digits accepted, rst_n=0 for 1 cycle, then 4'h5, 4'h5, 4'h5 with random in_valid gaps → single frame out_bin=222; no output for the aborted partial frame.
